// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA timing generator. Produces free-running horizontal and
// vertical counters (stage 0), decodes sync/active/window regions from them,
// and registers the sync pins, active flag and pixel colour one pixel tick
// later (stage 1). Line and frame start strobes are single-Clock pulses.
//
// The pixel source reads oHcounter/oVcounter (or oWinX/oWinY) and returns
// iRGB combinationally in the same cycle; the registered oRGB then lines up
// with the registered sync outputs.
//
// Ports:
//   Clock        in   system clock
//   Reset        in   synchronous, active-high reset (priority over Enable)
//   Enable       in   pixel tick; counters and stage-1 registers advance on 1
//   iRGB         in   [2:0] pixel colour {R,G,B} from the source
//   oHcounter    out  [COUNT_W-1:0] stage-0 horizontal counter
//   oVcounter    out  [COUNT_W-1:0] stage-0 vertical counter
//   oWinX        out  [COUNT_W-1:0] column relative to window, 0 outside
//   oWinY        out  [COUNT_W-1:0] line relative to window, 0 outside
//   oHsync       out  registered horizontal sync
//   oVsync       out  registered vertical sync
//   oActive      out  registered active-video flag
//   oRGB         out  [2:0] registered pixel output
//   oLineStart   out  one-Clock pulse after an enabled tick at H==0
//   oFrameStart  out  one-Clock pulse after an enabled tick at H==0, V==0
//   oFrameCount  out  [15:0] frame counter
//
// Optional feature (macro VGA_TIMING_FRAME_COUNT_EN):
//   defined   - oFrameCount counts frames mod 2^16, stepping together with
//               oFrameStart; cleared by Reset.
//   undefined - oFrameCount is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned COUNT_W    = 10,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        HSYNC_POL  = 1'b0,
  parameter logic        VSYNC_POL  = 1'b0,
  parameter int unsigned WIN_X0     = 192,
  parameter int unsigned WIN_Y0     = 112,
  parameter int unsigned WIN_W      = 256,
  parameter int unsigned WIN_H      = 256,
  parameter logic [2:0]  BORDER_RGB = 3'b000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enable,
  input  logic [2:0]         iRGB,
  output logic [COUNT_W-1:0] oHcounter,
  output logic [COUNT_W-1:0] oVcounter,
  output logic [COUNT_W-1:0] oWinX,
  output logic [COUNT_W-1:0] oWinY,
  output logic               oHsync,
  output logic               oVsync,
  output logic               oActive,
  output logic [2:0]         oRGB,
  output logic               oLineStart,
  output logic               oFrameStart,
  output logic [15:0]        oFrameCount
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned WIN_X1   = WIN_X0 + WIN_W;
  localparam int unsigned WIN_Y1   = WIN_Y0 + WIN_H;

  // ---------------------------------------------------------------------------
  // Stage 0: counters
  // ---------------------------------------------------------------------------
  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic [31:0]        h_ext;
  logic [31:0]        v_ext;
  logic               h_last;
  logic               v_last;
  logic               at_line_start;
  logic               at_frame_start;

  // Compare in 32 bits so geometry constants never get truncated to COUNT_W.
  assign h_ext          = 32'(h_count);
  assign v_ext          = 32'(v_count);
  assign h_last         = (h_ext == H_TOTAL - 1);
  assign v_last         = (v_ext == V_TOTAL - 1);
  assign at_line_start  = (h_count == '0);
  assign at_frame_start = (h_count == '0) && (v_count == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (Enable) begin
      if (h_last) begin
        h_count <= '0;
        if (v_last) begin
          v_count <= '0;
        end else begin
          v_count <= v_count + COUNT_W'(1);
        end
      end else begin
        h_count <= h_count + COUNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: region decode
  // ---------------------------------------------------------------------------
  logic               act;
  logic               hs;
  logic               vs;
  logic               win;
  logic [COUNT_W-1:0] win_x;
  logic [COUNT_W-1:0] win_y;
  logic [2:0]         rgb_next;

  always_comb begin
    act = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    hs  = (h_ext >= HS_START) && (h_ext < HS_END);
    vs  = (v_ext >= VS_START) && (v_ext < VS_END);
    // Window is clipped by the active area, so oversize geometry is harmless.
    win = (h_ext >= WIN_X0) && (h_ext < WIN_X1) &&
          (v_ext >= WIN_Y0) && (v_ext < WIN_Y1) && act;

    win_x = '0;
    win_y = '0;
    if (win) begin
      win_x = COUNT_W'(h_ext - WIN_X0);
      win_y = COUNT_W'(v_ext - WIN_Y0);
    end

    rgb_next = 3'b000;
    if (win) begin
      rgb_next = iRGB;
    end else if (act) begin
      rgb_next = BORDER_RGB;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered pins
  // ---------------------------------------------------------------------------
  logic       hsync_q;
  logic       vsync_q;
  logic       active_q;
  logic [2:0] rgb_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      active_q <= 1'b0;
      rgb_q    <= '0;
    end else if (Enable) begin
      hsync_q  <= hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_q  <= vs ? VSYNC_POL : ~VSYNC_POL;
      active_q <= act;
      rgb_q    <= rgb_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Strobes: loaded every Clock (not gated by Enable) so they self-clear
  // after one Clock even when Enable is held low.
  // ---------------------------------------------------------------------------
  logic line_start_q;
  logic frame_start_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= Enable && at_line_start;
      frame_start_q <= Enable && at_frame_start;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional frame counter
  // ---------------------------------------------------------------------------
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  // Steps on the same edge that raises oFrameStart, so the new count is
  // visible while the strobe is high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      frame_count_q <= '0;
    end else if (Enable && at_frame_start) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign oFrameCount = frame_count_q;
`else
  assign oFrameCount = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign oHcounter   = h_count;
  assign oVcounter   = v_count;
  assign oWinX       = win_x;
  assign oWinY       = win_y;
  assign oHsync      = hsync_q;
  assign oVsync      = vsync_q;
  assign oActive     = active_q;
  assign oRGB        = rgb_q;
  assign oLineStart  = line_start_q;
  assign oFrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. Two instances share Clock/Reset/Enable/
// iRGB:
//   dut_a - standard 800-clock line, shortened 10-line frame, window at
//           columns 192..447 / lines 2..4, border colour 3'b010, low syncs.
//   dut_b - 400-clock line (320/8/48/24), 7-line frame, high syncs, window
//           extending past the active area to show clipping.
// k counts enabled ticks since the last reset; the sample after tick k shows
// counter state k and stage-1 outputs decoded from state k-1.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic       Clock;
  logic       Reset;
  logic       Enable;
  logic [2:0] iRGB;

  logic [9:0]  h_a, v_a, wx_a, wy_a;
  logic        hs_a, vs_a, act_a, ls_a, fs_a;
  logic [2:0]  rgb_a;
  logic [15:0] fc_a;

  logic [9:0]  h_b, v_b, wx_b, wy_b;
  logic        hs_b, vs_b, act_b, ls_b, fs_b;
  logic [2:0]  rgb_b;
  logic [15:0] fc_b;

  vga_timing_gen #(
    .COUNT_W(10), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .WIN_X0(192), .WIN_Y0(2), .WIN_W(256), .WIN_H(3),
    .BORDER_RGB(3'b010)
  ) dut_a (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .iRGB(iRGB),
    .oHcounter(h_a), .oVcounter(v_a), .oWinX(wx_a), .oWinY(wy_a),
    .oHsync(hs_a), .oVsync(vs_a), .oActive(act_a), .oRGB(rgb_a),
    .oLineStart(ls_a), .oFrameStart(fs_a), .oFrameCount(fc_a)
  );

  vga_timing_gen #(
    .COUNT_W(10), .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .WIN_X0(300), .WIN_Y0(0), .WIN_W(100), .WIN_H(100),
    .BORDER_RGB(3'b000)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .iRGB(iRGB),
    .oHcounter(h_b), .oVcounter(v_b), .oWinX(wx_b), .oWinY(wy_b),
    .oHsync(hs_b), .oVsync(vs_b), .oActive(act_b), .oRGB(rgb_b),
    .oLineStart(ls_b), .oFrameStart(fs_b), .oFrameCount(fc_b)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned k;
  bit          stats_on;

  // Waveform statistics gathered over the first two frames of dut_a.
  int unsigned hs_low, hs_first, vs_low, vs_first, ls_cnt, fs_cnt;
  int unsigned hsb_high, hsb_first, vsb_first, lsb_cnt;
  logic [15:0] fc_seen [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    if (Enable && !Reset) k++;
    #1;
    if (stats_on) begin
      if (!hs_a) begin
        hs_low++;
        if (hs_first == 0) hs_first = k;
      end
      if (!vs_a) begin
        vs_low++;
        if (vs_first == 0) vs_first = k;
      end
      if (ls_a) ls_cnt++;
      if (fs_a) begin
        if (fs_cnt < 3) fc_seen[fs_cnt] = fc_a;
        fs_cnt++;
      end
      if (hs_b) begin
        hsb_high++;
        if (hsb_first == 0) hsb_first = k;
      end
      if (vs_b && vsb_first == 0) vsb_first = k;
      if (ls_b) lsb_cnt++;
    end
  endtask

  task automatic run_to(input int unsigned target);
    while (k < target) tick();
  endtask

  initial begin
    int first_pulse;
    int second_pulse;
    int pulse_clocks;

    n_pass = 0; n_total = 0; k = 0; stats_on = 1'b0;
    hs_low = 0; hs_first = 0; vs_low = 0; vs_first = 0; ls_cnt = 0; fs_cnt = 0;
    hsb_high = 0; hsb_first = 0; vsb_first = 0; lsb_cnt = 0;
    for (int i = 0; i < 3; i++) fc_seen[i] = 16'hffff;

    // Reset with Enable high: Reset wins.
    Reset = 1'b1; Enable = 1'b1; iRGB = 3'b111;
    tick();
    k = 0;
    chk("rst_h", 32'(h_a), 0);
    chk("rst_v", 32'(v_a), 0);
    chk("rst_hsync", 32'(hs_a), 1);
    chk("rst_vsync", 32'(vs_a), 1);
    chk("rst_active", 32'(act_a), 0);
    chk("rst_rgb", 32'(rgb_a), 0);
    chk("rst_ls", 32'(ls_a), 0);
    chk("rst_fs", 32'(fs_a), 0);
    chk("rst_fc", 32'(fc_a), 0);
    chk("rst_hsync_b", 32'(hs_b), 0);
    chk("rst_vsync_b", 32'(vs_b), 0);

    // First enabled tick after reset: (0,0) decoded, strobes fire.
    Reset = 1'b0; stats_on = 1'b1;
    tick();
    chk("t1_h", 32'(h_a), 1);
    chk("t1_ls", 32'(ls_a), 1);
    chk("t1_fs", 32'(fs_a), 1);
    chk("t1_active", 32'(act_a), 1);
    chk("t1_rgb_border", 32'(rgb_a), 3'b010);
    chk("t1_fc", 32'(fc_a), FC_EN ? 1 : 0);
    tick();
    chk("t2_ls_clear", 32'(ls_a), 0);
    chk("t2_fs_clear", 32'(fs_a), 0);

    // dut_b: window clipped at the right edge of the 320-pixel active area.
    run_to(319);
    chk("b_winx_319", 32'(wx_b), 19);
    run_to(320);
    chk("b_rgb_319", 32'(rgb_b), 3'b111);
    chk("b_act_319", 32'(act_b), 1);
    run_to(321);
    chk("b_rgb_320", 32'(rgb_b), 3'b000);
    chk("b_act_320", 32'(act_b), 0);
    run_to(350);
    chk("b_h_350", 32'(h_b), 350);
    chk("b_winx_clip", 32'(wx_b), 0);

    // dut_a window corners and border.
    run_to(1792);
    chk("a_h_192", 32'(h_a), 192);
    chk("a_v_2", 32'(v_a), 2);
    chk("a_winx_tl", 32'(wx_a), 0);
    chk("a_winy_tl", 32'(wy_a), 0);
    chk("a_rgb_191", 32'(rgb_a), 3'b010);
    run_to(1793);
    chk("a_rgb_192", 32'(rgb_a), 3'b111);
    run_to(2301);
    chk("a_rgb_700", 32'(rgb_a), 3'b000);
    chk("a_act_700", 32'(act_a), 0);
    run_to(3647);
    chk("a_winx_br", 32'(wx_a), 255);
    chk("a_winy_br", 32'(wy_a), 2);
    run_to(3648);
    chk("a_rgb_447", 32'(rgb_a), 3'b111);
    run_to(3649);
    chk("a_rgb_448", 32'(rgb_a), 3'b010);
    run_to(4192);
    chk("a_winx_below", 32'(wx_a), 0);
    chk("a_winy_below", 32'(wy_a), 0);
    run_to(4193);
    chk("a_rgb_below", 32'(rgb_a), 3'b010);
    run_to(4811);
    chk("a_act_vblank", 32'(act_a), 0);
    chk("a_rgb_vblank", 32'(rgb_a), 3'b000);

    // Two full frames of dut_a (states 0..16000).
    run_to(16001);
    stats_on = 1'b0;
    chk("hs_first_low", hs_first, 657);
    chk("hs_low_total", hs_low, 1920);
    chk("vs_first_low", vs_first, 5601);
    chk("vs_low_total", vs_low, 3200);
    chk("ls_count", ls_cnt, 21);
    chk("fs_count", fs_cnt, 3);
    chk("fc_at_fs0", 32'(fc_seen[0]), FC_EN ? 1 : 0);
    chk("fc_at_fs1", 32'(fc_seen[1]), FC_EN ? 2 : 0);
    chk("fc_at_fs2", 32'(fc_seen[2]), FC_EN ? 3 : 0);
    chk("b_hs_first_high", hsb_first, 329);
    chk("b_hs_high_total", hsb_high, 1920);
    chk("b_vs_first_high", vsb_first, 2001);
    chk("b_ls_count", lsb_cnt, 41);

    // Enable toggling 1,0,1,0 from state (1,0): line period doubles.
    first_pulse = -1; second_pulse = -1; pulse_clocks = 0;
    for (int c = 0; c < 3400; c++) begin
      Enable = (c % 2 == 0);
      tick();
      if (c == 0) chk("tog_h_adv", 32'(h_a), 2);
      if (c == 1) begin
        chk("tog_h_hold", 32'(h_a), 2);
        chk("tog_act_hold", 32'(act_a), 1);
        chk("tog_rgb_hold", 32'(rgb_a), 3'b010);
      end
      if (ls_a) begin
        pulse_clocks++;
        if (first_pulse < 0) first_pulse = c;
        else if (second_pulse < 0) second_pulse = c;
      end
    end
    chk("tog_first_ls", 32'(first_pulse), 1598);
    chk("tog_line_period", 32'(second_pulse - first_pulse), 1600);
    chk("tog_ls_clocks", 32'(pulse_clocks), 2);

    // Reset mid-frame at (400,3).
    Enable = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0; k = 0;
    run_to(2800);
    chk("pre_h", 32'(h_a), 400);
    chk("pre_v", 32'(v_a), 3);
    chk("pre_rgb", 32'(rgb_a), 3'b111);
    Reset = 1'b1;
    tick();
    chk("mid_rst_h", 32'(h_a), 0);
    chk("mid_rst_v", 32'(v_a), 0);
    chk("mid_rst_hsync", 32'(hs_a), 1);
    chk("mid_rst_vsync", 32'(vs_a), 1);
    chk("mid_rst_active", 32'(act_a), 0);
    chk("mid_rst_rgb", 32'(rgb_a), 0);
    chk("mid_rst_fs", 32'(fs_a), 0);
    chk("mid_rst_fc", 32'(fc_a), 0);
    Reset = 1'b0; Enable = 1'b0; k = 0;
    tick();
    chk("idle_h", 32'(h_a), 0);
    chk("idle_fs", 32'(fs_a), 0);
    Enable = 1'b1;
    tick();
    chk("resume_h", 32'(h_a), 1);
    chk("resume_fs", 32'(fs_a), 1);
    chk("resume_ls", 32'(ls_a), 1);
    chk("resume_fc", 32'(fc_a), FC_EN ? 1 : 0);
    tick();
    chk("resume_fs_clear", 32'(fs_a), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed-constant VGA controllers.
- Generates horizontal and vertical counters, sync pulses with configurable polarity, active-video flag and line/frame start strobes.
- Defines a display window; pixels outside it are forced to a border colour.
- Sits between the pixel source (which reads oHcounter/oVcounter) and the VGA pins. Enable allows a 50 MHz Clock with a 25 MHz pixel tick.

Parameters:
- COUNT_W, 10, width of the H/V counters; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- HSYNC_POL, 0, asserted level of oHsync.
- VSYNC_POL, 0, asserted level of oVsync.
- WIN_X0, 192, window left column.
- WIN_Y0, 112, window top line.
- WIN_W, 256, window width.
- WIN_H, 256, window height.
- BORDER_RGB, 3'b000, colour output inside active video but outside the window.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  pixel tick; counters and stage-1 registers advance only when it is 1.
- iRGB  in  3  pixel colour {R,G,B}, computed combinationally by the source from oHcounter/oVcounter in the same cycle.
- oHcounter  out  COUNT_W  stage-0 horizontal counter.
- oVcounter  out  COUNT_W  stage-0 vertical counter.
- oWinX  out  COUNT_W  oHcounter-WIN_X0 when inside the window, else 0 (stage 0).
- oWinY  out  COUNT_W  oVcounter-WIN_Y0 when inside the window, else 0 (stage 0).
- oHsync  out  1  registered horizontal sync (stage 1).
- oVsync  out  1  registered vertical sync (stage 1).
- oActive  out  1  registered active-video flag (stage 1).
- oRGB  out  3  registered pixel output (stage 1).
- oLineStart  out  1  one-Clock pulse at the start of each line.
- oFrameStart  out  1  one-Clock pulse at the start of each frame.
- oFrameCount  out  16  frame counter (optional feature only).

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal counter: when Enable=1, H increments. At H_TOTAL-1 it wraps to 0 and V increments; V wraps to 0 at V_TOTAL-1 on that same tick.
- Enable=0: counters and all stage-1 outputs hold; oLineStart and oFrameStart are 0.
- Decode from stage 0:
  - act = H<H_ACTIVE && V<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= H < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= V < V_ACTIVE+V_FP+V_SYNC.
  - win = WIN_X0<=H<WIN_X0+WIN_W && WIN_Y0<=V<WIN_Y0+WIN_H && act.
- Stage 1 registers update on Clock when Enable=1. Latency is one Enable tick from counter value to pin.
  - oHsync = hs ? HSYNC_POL : ~HSYNC_POL.
  - oVsync = vs ? VSYNC_POL : ~VSYNC_POL.
  - oActive = act.
  - oRGB = win ? iRGB : (act ? BORDER_RGB : 3'b000).
- Pulses:
  - oLineStart is 1 for exactly one Clock cycle after an Enable cycle in which H==0.
  - oFrameStart is 1 for exactly one Clock cycle after an Enable cycle in which H==0 and V==0.
  - Both are cleared on the next Clock regardless of Enable.
- Reset (any cycle, including mid-line or mid-frame): on the next Clock edge H=V=0, oHsync=~HSYNC_POL, oVsync=~VSYNC_POL, oActive=0, oRGB=0, pulses 0, oFrameCount=0. Reset has priority over Enable. Counting resumes from (0,0) on the first Enable after Reset falls.
- Window geometry exceeding the active area is clipped by act; no error is raised.
- Counter values never exceed H_TOTAL-1 or V_TOTAL-1. Out-of-range values cannot occur after Reset.

Optional Feature:
- Macro VGA_TIMING_FRAME_COUNT_EN.
- Defined: oFrameCount increments (mod 2^16) in the same cycle oFrameStart asserts, and resets to 0.
- Undefined: oFrameCount is tied to 16'd0 and no counter logic is built.

Test Plan:
- Default parameters, Enable=1 every cycle, run 2 frames:
  - oHsync low for exactly 96 cycles per line, starting 657 cycles after H==0 (656 + 1 latency).
  - oVsync low for exactly 2 lines per frame.
  - Period is 800x525 = 420000 cycles per frame.
- Enable toggling 1,0,1,0: counters advance every 2nd Clock; line period is 1600 Clocks; pulses remain 1 Clock wide.
- iRGB=3'b111, BORDER_RGB=3'b010:
  - (H,V)=(192,112) → oRGB=111 one tick later.
  - (191,112) → 010.
  - (700,112) → 000.
  - oWinX/oWinY = (0,0) at (192,112) and (255,255) at (447,367).
- Assert Reset at H=400, V=300 for 1 cycle: next cycle H=V=0, oHsync=oVsync=1, oActive=0, oRGB=0; oFrameStart pulses on the following Enable.
- HSYNC_POL=1, VSYNC_POL=1, H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24: line=400 cycles; oHsync high for H in 328..375.
- With VGA_TIMING_FRAME_COUNT_EN defined, run 3 frames: oFrameCount reads 1, 2, 3 coincident with each oFrameStart. Without the macro it stays 0.
